// File: rtl/led_pattern_pkg.sv
// Shared encodings and helpers for the multi-channel LED pattern driver.
package led_pattern_pkg;

  localparam logic [1:0] MODE_OFF   = 2'd0;
  localparam logic [1:0] MODE_ON    = 2'd1;
  localparam logic [1:0] MODE_BLINK = 2'd2;
  localparam logic [1:0] MODE_BURST = 2'd3;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ON_PH  = 2'd1;
  localparam logic [1:0] ST_OFF_PH = 2'd2;
  localparam logic [1:0] ST_GAP    = 2'd3;

  function automatic int unsigned calc_div(input int unsigned clk_hz,
                                           input int unsigned tick_hz);
    return clk_hz / tick_hz;
  endfunction

endpackage

// File: rtl/led_chan.sv
// One LED channel: latched config, pattern FSM, phase/pulse counters, registered active-low drive.
module led_chan
  import led_pattern_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             we,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] half,
  input  logic [3:0]       pulses,
  output logic             led_n
);

  logic [1:0]       mode_q, mode_d;
  logic [CNT_W-1:0] half_q, half_d;
  logic [3:0]       pulses_q, pulses_d;
  logic [1:0]       state_q, state_d;
  logic [CNT_W+1:0] cnt_q, cnt_d;
  logic [3:0]       pcnt_q, pcnt_d;
  logic             led_n_q, led_n_d;

  logic [CNT_W+1:0] phase_last;
  logic [CNT_W+1:0] gap_last;
  logic [3:0]       pcnt_inc;

  // half is stored already normalised (0 -> 1), so these never underflow
  assign phase_last = {2'b00, half_q} - 1'b1;
  assign gap_last   = {half_q, 2'b00} - 1'b1;
  assign pcnt_inc   = pcnt_q + 4'd1;

  always_comb begin
    mode_d   = mode_q;
    half_d   = half_q;
    pulses_d = pulses_q;
    state_d  = state_q;
    cnt_d    = cnt_q;
    pcnt_d   = pcnt_q;
    if (we) begin
      mode_d   = mode;
      half_d   = (half == '0) ? CNT_W'(1) : half;
      pulses_d = (pulses == '0) ? 4'd1 : pulses;
      state_d  = (mode == MODE_BLINK || mode == MODE_BURST) ? ST_ON_PH : ST_IDLE;
      cnt_d    = '0;
      pcnt_d   = '0;
    end else if (tick) begin
      unique case (state_q)
        ST_ON_PH: begin
          if (cnt_q == phase_last) begin
            state_d = ST_OFF_PH;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_OFF_PH: begin
          if (cnt_q == phase_last) begin
            cnt_d   = '0;
            state_d = ST_ON_PH;
            if (mode_q == MODE_BURST) begin
              pcnt_d = pcnt_inc;
              if (pcnt_inc == pulses_q) state_d = ST_GAP;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_GAP: begin
          if (cnt_q == gap_last) begin
            state_d = ST_ON_PH;
            cnt_d   = '0;
            pcnt_d  = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
    led_n_d = !((state_d == ST_ON_PH) || (state_d == ST_IDLE && mode_d == MODE_ON));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q   <= MODE_OFF;
      half_q   <= CNT_W'(1);
      pulses_q <= 4'd1;
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      pcnt_q   <= '0;
      led_n_q  <= 1'b1;
    end else begin
      mode_q   <= mode_d;
      half_q   <= half_d;
      pulses_q <= pulses_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pcnt_q   <= pcnt_d;
      led_n_q  <= led_n_d;
    end
  end

  assign led_n = led_n_q;

endmodule

// File: rtl/led_pattern_ctrl.sv
// Multi-channel LED pattern driver: shared prescaler, config write decode, per-channel engines.
module led_pattern_ctrl
  import led_pattern_pkg::*;
#(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned CLK_HZ  = 200_000_000,
  parameter int unsigned TICK_HZ = 1000,
  parameter int unsigned CNT_W   = 16,
  localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [1:0]        cfg_mode,
  input  logic [CNT_W-1:0]  cfg_half,
  input  logic [3:0]        cfg_pulses,
  output logic [NUM_CH-1:0] led_n,
  output logic              tick
);

  localparam int unsigned DIV   = calc_div(CLK_HZ, TICK_HZ);
  localparam int unsigned PRE_W = $clog2(DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

  logic [PRE_W-1:0] pre_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q <= '0;
    end else if (pre_q == PRE_LAST) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_q + 1'b1;
    end
  end

  assign tick = (pre_q == PRE_LAST);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic ch_we;
    // Out-of-range channel indices simply match no instance
    assign ch_we = cfg_we && (int'(cfg_ch) == i);

    led_chan #(
      .CNT_W(CNT_W)
    ) u_chan (
      .clk   (clk),
      .rst   (rst),
      .tick  (tick),
      .we    (ch_we),
      .mode  (cfg_mode),
      .half  (cfg_half),
      .pulses(cfg_pulses),
      .led_n (led_n[i])
    );
  end

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Randomised bench for led_pattern_ctrl against a tick-count pattern model.
module tb_led_pattern_ctrl;

  localparam int NUM_CH = 4;
  localparam int DIV    = 10;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              cfg_we;
  logic [1:0]        cfg_ch;
  logic [1:0]        cfg_mode;
  logic [CNT_W-1:0]  cfg_half;
  logic [3:0]        cfg_pulses;
  logic [NUM_CH-1:0] led_n;
  logic              tick;

  led_pattern_ctrl #(
    .NUM_CH (NUM_CH),
    .CLK_HZ (10),
    .TICK_HZ(1),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_mode  (cfg_mode),
    .cfg_half  (cfg_half),
    .cfg_pulses(cfg_pulses),
    .led_n     (led_n),
    .tick      (tick)
  );

  always #5 clk = ~clk;

  // Model: per channel, the config and the number of ticks seen since the last write
  int m_mode[NUM_CH];
  int m_half[NUM_CH];
  int m_pulses[NUM_CH];
  int m_nt[NUM_CH];
  int cyc;
  int n_cmp = 0;
  int n_bad = 0;

  function automatic bit model_lit(int mode, int half, int pulses, int nt);
    int h, p, period, pos;
    h = (half == 0) ? 1 : half;
    p = (pulses == 0) ? 1 : pulses;
    case (mode)
      0: return 1'b0;
      1: return 1'b1;
      2: return ((nt / h) % 2) == 0;
      default: begin
        period = 2 * h * p + 4 * h;
        pos    = nt % period;
        return (pos < 2 * h * p) && (((pos / h) % 2) == 0);
      end
    endcase
  endfunction

  function automatic bit tick_exp();
    return (cyc % DIV) == DIV - 1;
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  // Inputs are set before calling; one clock edge is applied, modelled and checked.
  task automatic cycle_step(input string tag);
    bit ticked;
    logic [NUM_CH-1:0] exp_led;
    ticked = tick_exp();
    @(posedge clk);
    if (rst) begin
      cyc = 0;
      for (int c = 0; c < NUM_CH; c++) begin
        m_mode[c] = 0; m_half[c] = 1; m_pulses[c] = 1; m_nt[c] = 0;
      end
    end else begin
      cyc++;
      for (int c = 0; c < NUM_CH; c++) begin
        if (cfg_we && int'(cfg_ch) == c) begin
          m_mode[c] = int'(cfg_mode); m_half[c] = int'(cfg_half);
          m_pulses[c] = int'(cfg_pulses); m_nt[c] = 0;
        end else if (ticked) begin
          m_nt[c]++;
        end
      end
    end
    @(negedge clk);
    for (int c = 0; c < NUM_CH; c++)
      exp_led[c] = !model_lit(m_mode[c], m_half[c], m_pulses[c], m_nt[c]);
    check({tag, "_led_n"}, int'(led_n), int'(exp_led));
    check({tag, "_tick"}, int'(tick), int'(tick_exp()));
    cfg_we = 1'b0;
    rst    = 1'b0;
  endtask

  task automatic idle(input string tag, input int n);
    for (int k = 0; k < n; k++) cycle_step(tag);
  endtask

  task automatic do_write(input string tag, input int ch, input int mode, input int half,
                          input int pulses);
    cfg_we     = 1'b1;
    cfg_ch     = 2'(ch);
    cfg_mode   = 2'(mode);
    cfg_half   = CNT_W'(half);
    cfg_pulses = 4'(pulses);
    cycle_step(tag);
  endtask

  initial begin
    bit found;
    rst = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_mode = '0; cfg_half = '0; cfg_pulses = '0;
    cyc = 0;
    @(negedge clk);
    rst = 1'b1;
    cycle_step("reset");
    rst = 1'b1;
    cycle_step("reset2");

    idle("t1_idle", 100);

    do_write("t2_on", 2, 1, 0, 0);
    idle("t2_on_hold", 15);
    do_write("t2_off", 2, 0, 0, 0);
    idle("t2_off_hold", 15);

    while (!tick_exp()) cycle_step("t3_align");
    cycle_step("t3_after_tick");
    do_write("t3_blink", 0, 2, 3, 0);
    idle("t3_run", 620);

    do_write("t4_burst", 1, 3, 1, 2);
    idle("t4_run", 200);

    do_write("t5_half0", 3, 2, 0, 0);
    idle("t5_run", 45);
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      if (tick_exp() && !model_lit(m_mode[3], m_half[3], m_pulses[3], m_nt[3])) begin
        do_write("t5_tick_write", 3, 2, 0, 0);
        found = 1'b1;
      end else begin
        cycle_step("t5_seek");
      end
    end
    check("t5_found_off_tick", int'(found), 1);
    idle("t5_after", 40);

    do_write("t6_burst", 1, 3, 2, 3);
    idle("t6_run", 37);
    rst = 1'b1;
    cycle_step("t6_reset");
    idle("t6_after", 30);

    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 999) < 3) begin
        rst = 1'b1;
        cycle_step("rnd_reset");
      end else if ($urandom_range(0, 99) < 4) begin
        do_write("rnd_write", int'($urandom_range(0, NUM_CH - 1)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 4)), int'($urandom_range(0, 3)));
      end else begin
        cycle_step("rnd_idle");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
